// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel enable, h/v counters, blanking, sync and frame markers
// for NTSC/PAL at 15 kHz or scandoubled. Mode changes are taken only at the (0,0) wrap.
module video_timing_gen #(
    parameter int unsigned CW        = 11,
    parameter int unsigned H_ACTIVE  = 529,
    parameter int unsigned H_FP      = 15,
    parameter int unsigned H_SYNC    = 46,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned NV_ACTIVE = 240,
    parameter int unsigned NV_FP     = 5,
    parameter int unsigned NV_SYNC   = 3,
    parameter int unsigned NV_BP     = 14,
    parameter int unsigned PV_ACTIVE = 300,
    parameter int unsigned PV_FP     = 4,
    parameter int unsigned PV_SYNC   = 4,
    parameter int unsigned PV_BP     = 4,
    parameter int unsigned CE_DIV    = 2,
    parameter int unsigned HS_POL    = 1,
    parameter int unsigned VS_POL    = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          pal,
    input  logic          scandouble,
    output logic          ce_pix,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic [CW-1:0] src_line,
    output logic          hblank,
    output logic          vblank,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          frame_start,
    output logic [7:0]    frame_cnt,
    output logic [1:0]    mode_act
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned DW       = $clog2(CE_DIV);
    localparam logic [DW-1:0] DIV_LAST_LO = DW'(CE_DIV - 1);
    localparam logic [DW-1:0] DIV_LAST_SD = DW'(CE_DIV / 2 - 1);
    localparam logic HS_ON = HS_POL[0];
    localparam logic VS_ON = VS_POL[0];

    // Vertical line count for mode m = {pal, scandouble}; doubled modes scale every value by 2.
    function automatic int unsigned v_scale(input logic [1:0] m, input int unsigned ntsc_v,
                                            input int unsigned pal_v);
        int unsigned base;
        base = m[1] ? pal_v : ntsc_v;
        return m[0] ? (base * 2) : base;
    endfunction

    logic [1:0]    mode_q, mode_d;
    logic [DW-1:0] div_q, div_d;
    logic          ce_q, ce_d;
    logic [CW-1:0] hcount_q, hcount_d;
    logic [CW-1:0] vcount_q, vcount_d;
    logic [CW-1:0] src_q, src_d;
    logic          hblank_q, hblank_d;
    logic          vblank_q, vblank_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          de_q, de_d;
    logic          fs_q, fs_d;
    logic [7:0]    fcnt_q, fcnt_d;
    logic [DW-1:0] div_last;
    logic [CW-1:0] v_last;
    logic [CW-1:0] v_act_n, vs_start_n, vs_end_n;

    // Next-state counters, mode latch, and decode of the next counter values.
    always_comb begin
        mode_d   = mode_q;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        fs_d     = 1'b0;
        fcnt_d   = fcnt_q;

        div_last = mode_q[0] ? DIV_LAST_SD : DIV_LAST_LO;
        v_last   = CW'(v_scale(mode_q, NV_ACTIVE + NV_FP + NV_SYNC + NV_BP,
                               PV_ACTIVE + PV_FP + PV_SYNC + PV_BP) - 1);
        ce_d     = (div_q == div_last);
        div_d    = ce_d ? '0 : div_q + DW'(1);

        if (ce_d) begin
            if (hcount_q == CW'(H_TOTAL - 1)) begin
                hcount_d = '0;
                if (vcount_q == v_last) begin
                    vcount_d = '0;
                    fs_d     = 1'b1;
                    fcnt_d   = fcnt_q + 8'd1;
                    mode_d   = {pal, scandouble};
                end else begin
                    vcount_d = vcount_q + CW'(1);
                end
            end else begin
                hcount_d = hcount_q + CW'(1);
            end
        end

        v_act_n    = CW'(v_scale(mode_d, NV_ACTIVE, PV_ACTIVE));
        vs_start_n = CW'(v_scale(mode_d, NV_ACTIVE + NV_FP, PV_ACTIVE + PV_FP));
        vs_end_n   = CW'(v_scale(mode_d, NV_ACTIVE + NV_FP + NV_SYNC, PV_ACTIVE + PV_FP + PV_SYNC));

        hblank_d = (hcount_d >= CW'(H_ACTIVE));
        vblank_d = (vcount_d >= v_act_n);
        hsync_d  = ((hcount_d >= CW'(HS_START)) && (hcount_d < CW'(HS_END))) ? HS_ON : ~HS_ON;
        vsync_d  = ((vcount_d >= vs_start_n) && (vcount_d < vs_end_n)) ? VS_ON : ~VS_ON;
        de_d     = ~hblank_d & ~vblank_d;
        src_d    = mode_d[0] ? (vcount_d >> 1) : vcount_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q   <= {pal, scandouble};
            div_q    <= '0;
            ce_q     <= 1'b0;
            hcount_q <= '0;
            vcount_q <= '0;
            src_q    <= '0;
            hblank_q <= 1'b0;
            vblank_q <= 1'b0;
            hsync_q  <= ~HS_ON;
            vsync_q  <= ~VS_ON;
            de_q     <= 1'b1;
            fs_q     <= 1'b0;
            fcnt_q   <= 8'd0;
        end else begin
            mode_q   <= mode_d;
            div_q    <= div_d;
            ce_q     <= ce_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            src_q    <= src_d;
            hblank_q <= hblank_d;
            vblank_q <= vblank_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            de_q     <= de_d;
            fs_q     <= fs_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign ce_pix      = ce_q;
    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign src_line    = src_q;
    assign hblank      = hblank_q;
    assign vblank      = vblank_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fcnt_q;
    assign mode_act    = mode_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small raster, two polarity builds, checked every clk against a
// linear pixel-index reference model.
module tb_video_timing_gen;

    localparam int unsigned CW  = 6;
    localparam int unsigned HA  = 6, HFP = 2, HSW = 3, HBP = 2;
    localparam int unsigned NVA = 4, NVF = 1, NVS = 2, NVB = 1;
    localparam int unsigned PVA = 5, PVF = 1, PVS = 1, PVB = 2;
    localparam int unsigned CED = 2;
    localparam int unsigned HT  = HA + HFP + HSW + HBP;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic pal = 1'b0;
    logic sd = 1'b0;

    logic          p_ce, p_hb, p_vb, p_hs, p_vs, p_de, p_fs;
    logic [CW-1:0] p_hc, p_vc, p_src;
    logic [7:0]    p_fcnt;
    logic [1:0]    p_mode;
    logic          n_ce, n_hb, n_vb, n_hs, n_vs, n_de, n_fs;
    logic [CW-1:0] n_hc, n_vc, n_src;
    logic [7:0]    n_fcnt;
    logic [1:0]    n_mode;

    always #5 clk = ~clk;

    video_timing_gen #(.CW(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .NV_ACTIVE(NVA), .NV_FP(NVF), .NV_SYNC(NVS), .NV_BP(NVB),
        .PV_ACTIVE(PVA), .PV_FP(PVF), .PV_SYNC(PVS), .PV_BP(PVB),
        .CE_DIV(CED), .HS_POL(1), .VS_POL(1)) dut_p (
        .clk(clk), .reset_n(reset_n), .pal(pal), .scandouble(sd), .ce_pix(p_ce),
        .hcount(p_hc), .vcount(p_vc), .src_line(p_src), .hblank(p_hb), .vblank(p_vb),
        .hsync(p_hs), .vsync(p_vs), .de(p_de), .frame_start(p_fs), .frame_cnt(p_fcnt),
        .mode_act(p_mode));

    video_timing_gen #(.CW(CW), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .NV_ACTIVE(NVA), .NV_FP(NVF), .NV_SYNC(NVS), .NV_BP(NVB),
        .PV_ACTIVE(PVA), .PV_FP(PVF), .PV_SYNC(PVS), .PV_BP(PVB),
        .CE_DIV(CED), .HS_POL(0), .VS_POL(0)) dut_n (
        .clk(clk), .reset_n(reset_n), .pal(pal), .scandouble(sd), .ce_pix(n_ce),
        .hcount(n_hc), .vcount(n_vc), .src_line(n_src), .hblank(n_hb), .vblank(n_vb),
        .hsync(n_hs), .vsync(n_vs), .de(n_de), .frame_start(n_fs), .frame_cnt(n_fcnt),
        .mode_act(n_mode));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rel = 0;
    int fs_times[$];

    // Reference model: divider phase, linear pixel index in the frame, frame count, mode.
    logic [1:0] m_mode;
    int         m_c, m_p;
    logic [7:0] m_fcnt;
    logic       m_ce, m_fs;

    function automatic int vtot(input logic [1:0] m);
        int base;
        base = m[1] ? int'(PVA + PVF + PVS + PVB) : int'(NVA + NVF + NVS + NVB);
        return m[0] ? 2 * base : base;
    endfunction

    task automatic model_edge();
        int d;
        if (!reset_n) begin
            m_mode = {pal, sd};
            m_c = 0; m_p = 0; m_fcnt = 8'd0; m_ce = 1'b0; m_fs = 1'b0;
        end else begin
            d = m_mode[0] ? int'(CED / 2) : int'(CED);
            m_ce = 1'b0; m_fs = 1'b0;
            m_c = m_c + 1;
            if (m_c == d) begin
                m_c = 0; m_ce = 1'b1; m_p = m_p + 1;
                if (m_p == int'(HT) * vtot(m_mode)) begin
                    m_p = 0; m_fs = 1'b1; m_fcnt = m_fcnt + 8'd1; m_mode = {pal, sd};
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        int h, v, k, va, vss, vse;
        logic hb, vb, hs, vs;
        h   = m_p % int'(HT);
        v   = m_p / int'(HT);
        k   = m_mode[0] ? 2 : 1;
        va  = k * (m_mode[1] ? int'(PVA) : int'(NVA));
        vss = k * (m_mode[1] ? int'(PVA + PVF) : int'(NVA + NVF));
        vse = vss + k * (m_mode[1] ? int'(PVS) : int'(NVS));
        hb  = (h >= int'(HA));
        vb  = (v >= va);
        hs  = (h >= int'(HA + HFP)) && (h < int'(HA + HFP + HSW));
        vs  = (v >= vss) && (v < vse);
        check("ce_pix",      32'(p_ce),   32'(m_ce));
        check("hcount",      32'(p_hc),   32'(h));
        check("vcount",      32'(p_vc),   32'(v));
        check("src_line",    32'(p_src),  32'(v >> (m_mode[0] ? 1 : 0)));
        check("hblank",      32'(p_hb),   32'(hb));
        check("vblank",      32'(p_vb),   32'(vb));
        check("hsync",       32'(p_hs),   32'(hs));
        check("vsync",       32'(p_vs),   32'(vs));
        check("de",          32'(p_de),   32'(!hb && !vb));
        check("frame_start", 32'(p_fs),   32'(m_fs));
        check("frame_cnt",   32'(p_fcnt), 32'(m_fcnt));
        check("mode_act",    32'(p_mode), 32'(m_mode));
        check("hsync_neg",   32'(n_hs),   32'(!hs));
        check("vsync_neg",   32'(n_vs),   32'(!vs));
        check("hcount_neg",  32'(n_hc),   32'(h));
        check("fcnt_neg",    32'(n_fcnt), 32'(m_fcnt));
    endtask

    task automatic finish_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        @(negedge clk);
        check_all();
        if (p_fs === 1'b1) fs_times.push_back(cyc);
        if (errors > 100) finish_run();
    endtask

    initial begin
        int found;
        int nfs;

        // Reset held 3 clks in NTSC 15 kHz
        reset_n = 1'b0; pal = 1'b0; sd = 1'b0;
        repeat (3) step();
        check("rst_de",     32'(p_de),   32'd1);
        check("rst_hsync",  32'(p_hs),   32'd0);
        check("rst_hsyncn", 32'(n_hs),   32'd1);
        check("rst_mode",   32'(p_mode), 32'd0);

        // Two NTSC frames: first frame_start and frame period
        reset_n = 1'b1;
        rel = cyc;
        fs_times.delete();
        step();
        check("first_ce_not_yet", 32'(p_ce), 32'd0);
        step();
        check("first_ce", 32'(p_ce), 32'd1);
        for (int i = 0; i < 1000 && fs_times.size() < 2; i++) step();
        check("ntsc_two_frames", 32'(fs_times.size() >= 2), 32'd1);
        if (fs_times.size() >= 2) begin
            check("ntsc_first_fs", 32'(fs_times[0] - rel), 32'(HT * (NVA + NVF + NVS + NVB) * CED));
            check("ntsc_period",   32'(fs_times[1] - fs_times[0]), 32'(HT * (NVA + NVF + NVS + NVB) * CED));
        end
        check("fcnt_two", 32'(p_fcnt), 32'd2);

        // Mid-frame request for PAL scandoubled: takes effect only at the wrap
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            step();
            if (m_p / int'(HT) == 4) found = 1;
        end
        check("reach_line4", 32'(found), 32'd1);
        pal = 1'b1; sd = 1'b1;
        step();
        check("mode_held", 32'(p_mode), 32'd0);
        fs_times.delete();
        for (int i = 0; i < 1000 && fs_times.size() < 2; i++) step();
        check("pal_sd_frames", 32'(fs_times.size() >= 2), 32'd1);
        check("mode_pal_sd", 32'(p_mode), 32'd3);
        if (fs_times.size() >= 2)
            check("pal_sd_period", 32'(fs_times[1] - fs_times[0]), 32'(HT * 2 * (PVA + PVF + PVS + PVB)));

        // Reset mid-frame
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            step();
            if (m_p % int'(HT) == 7 && m_p / int'(HT) == 5) found = 1;
        end
        check("reach_mid", 32'(found), 32'd1);
        reset_n = 1'b0;
        step();
        check("midrst_h",    32'(p_hc),   32'd0);
        check("midrst_v",    32'(p_vc),   32'd0);
        check("midrst_fs",   32'(p_fs),   32'd0);
        check("midrst_fcnt", 32'(p_fcnt), 32'd0);
        reset_n = 1'b1;

        // Random mode toggling with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(7) == 0) pal = 1'($urandom_range(1));
            if ($urandom_range(7) == 0) sd  = 1'($urandom_range(1));
            reset_n = ($urandom_range(499) == 0) ? 1'b0 : 1'b1;
            step();
        end

        // frame_cnt wrap 255 -> 0 after 256 frames
        reset_n = 1'b0; pal = 1'($urandom_range(1)); sd = 1'b1;
        step();
        reset_n = 1'b1;
        nfs = 0;
        for (int i = 0; i < 70000 && nfs < 256; i++) begin
            step();
            if (p_fs === 1'b1) nfs++;
        end
        check("wrap_frames", 32'(nfs), 32'd256);
        check("wrap_fcnt",   32'(p_fcnt), 32'd0);
        check("wrap_fcntn",  32'(n_fcnt), 32'd0);

        finish_run();
    end

endmodule
